// File: rtl/seq_pkg.sv
// Shared types and helpers for the cyclic sequence engine and its scheduler.
// The sequence runs 1,2,3,6,4 and then wraps back to 1.
package seq_pkg;

    localparam int SEQ_W = 4;

    typedef enum logic [2:0] {
        P0 = 3'd0,
        P1 = 3'd1,
        P2 = 3'd2,
        P3 = 3'd3,
        P4 = 3'd4
    } seq_pos_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    // Value emitted at each position; an unknown encoding reads as zero.
    function automatic logic [SEQ_W-1:0] seq_value(input seq_pos_t pos);
        logic [SEQ_W-1:0] val;
        case (pos)
            P0:      val = 4'd1;
            P1:      val = 4'd2;
            P2:      val = 4'd3;
            P3:      val = 4'd6;
            P4:      val = 4'd4;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

    function automatic seq_pos_t seq_next(input seq_pos_t pos);
        seq_pos_t nxt;
        case (pos)
            P0:      nxt = P1;
            P1:      nxt = P2;
            P2:      nxt = P3;
            P3:      nxt = P4;
            P4:      nxt = P0;
            default: nxt = P0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_step_engine.sv
// Five-state Moore sequence generator; moves one position per cycle while advance is high.
module seq_step_engine
    import seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output seq_pos_t         pos,
    output logic [SEQ_W-1:0] value
);

    seq_pos_t pos_q;
    seq_pos_t pos_d;

    // Next position: step on advance, otherwise hold.
    always_comb begin
        pos_d = pos_q;
        if (advance) begin
            pos_d = seq_next(pos_q);
        end else begin
            pos_d = pos_q;
        end
    end

    // Position register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= P0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos   = pos_q;
    assign value = seq_value(pos_q);

endmodule

// File: rtl/seq_gen_scheduler.sv
// Round-robin scheduler sharing one sequence engine between NUM_REQ requesters;
// the granted requester receives a burst of req_len beats over valid/ready.
module seq_gen_scheduler
    import seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int OUT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

    sched_state_t state_q;
    sched_state_t state_d;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [PTR_W-1:0]   win_idx_q;
    logic [PTR_W-1:0]   win_idx_d;
    logic               out_valid_q;
    logic               out_valid_d;
    logic               out_last_q;
    logic               out_last_d;
    logic [OUT_W-1:0]   out_data_q;
    logic [OUT_W-1:0]   out_data_d;

    logic               pick_found_s;
    logic [PTR_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [LEN_W-1:0]   pick_len_s;
    logic               fire_s;
    logic               last_fire_s;
    logic [PTR_W-1:0]   rr_next_s;
    seq_pos_t           eng_pos_s;
    logic [SEQ_W-1:0]   eng_value_s;

    assign fire_s      = (state_q == BURST) && out_valid_q && out_ready;
    assign last_fire_s = fire_s && (cnt_q == CNT_W'(1));
    assign rr_next_s   = (win_idx_q == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : (win_idx_q + PTR_W'(1));

    seq_step_engine u_engine (
        .clk     (clk),
        .rst     (rst),
        .advance (fire_s),
        .pos     (eng_pos_s),
        .value   (eng_value_s)
    );

    // Round-robin pick: scanning from rr_ptr upward, the first set request wins.
    always_comb begin
        logic [PTR_W:0] idx_v;
        pick_found_s = 1'b0;
        pick_idx_s   = {PTR_W{1'b0}};
        idx_v        = {(PTR_W+1){1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_v = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            idx_v = (idx_v >= (PTR_W+1)'(NUM_REQ)) ? (idx_v - (PTR_W+1)'(NUM_REQ)) : idx_v;
            pick_idx_s   = req[idx_v[PTR_W-1:0]] ? idx_v[PTR_W-1:0] : pick_idx_s;
            pick_found_s = pick_found_s | req[idx_v[PTR_W-1:0]];
        end
    end

    // Winner's one-hot grant and burst length field.
    always_comb begin
        pick_onehot_s = {NUM_REQ{1'b0}};
        pick_len_s    = {LEN_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_onehot_s[i] = (pick_idx_s == PTR_W'(i));
            pick_len_s       = (pick_idx_s == PTR_W'(i)) ? req_len[i*LEN_W +: LEN_W] : pick_len_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_found_s ? BURST : IDLE;
            BURST:   state_d = last_fire_s ? IDLE : BURST;
            default: state_d = IDLE;
        endcase
    end

    // Grant, beat counter, pointer and registered output values.
    always_comb begin
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        win_idx_d = win_idx_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    gnt_d     = pick_onehot_s;
                    cnt_d     = (pick_len_s == {LEN_W{1'b0}}) ? CNT_FULL : {1'b0, pick_len_s};
                    win_idx_d = pick_idx_s;
                end else begin
                    gnt_d     = {NUM_REQ{1'b0}};
                end
            end
            BURST: begin
                if (last_fire_s) begin
                    gnt_d    = {NUM_REQ{1'b0}};
                    cnt_d    = cnt_q - CNT_W'(1);
                    rr_ptr_d = rr_next_s;
                end else if (fire_s) begin
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            default: begin
                gnt_d = {NUM_REQ{1'b0}};
            end
        endcase
        out_valid_d = (state_d == BURST);
        out_last_d  = (state_d == BURST) && (cnt_d == CNT_W'(1));
        // Track the value the engine will hold after this edge so out_data stays registered.
        out_data_d  = fire_s ? OUT_W'(seq_value(seq_next(eng_pos_s))) : OUT_W'(eng_value_s);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= {NUM_REQ{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            rr_ptr_q    <= {PTR_W{1'b0}};
            win_idx_q   <= {PTR_W{1'b0}};
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= OUT_W'(seq_value(P0));
        end else begin
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            win_idx_q   <= win_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_seq_gen_scheduler.sv
// Bench for seq_gen_scheduler: directed scenarios plus random traffic, all checked
// against a transaction-level model of bursts, round-robin order and sequence position.
module tb_seq_gen_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LEN_W   = 4;
    localparam int OUT_W   = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       gnt;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;

    int n_checks;
    int n_errors;

    int seq_tab [5] = '{1, 2, 3, 6, 4};
    bit m_active;
    int m_pos;
    int m_rr;
    int m_win;
    int m_rem;

    seq_gen_scheduler #(
        .NUM_REQ (NUM_REQ),
        .LEN_W   (LEN_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_rr     = 0;
        m_win    = 0;
        m_rem    = 0;
    endtask

    // Effect of one rising edge given the inputs currently driven.
    task automatic model_edge();
        int len;
        if (m_active) begin
            if (out_ready) begin
                m_pos = (m_pos + 1) % 5;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_active = 1'b0;
                    m_rr     = (m_win + 1) % NUM_REQ;
                end
            end
        end else if (req != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!m_active && req[(m_rr + k) % NUM_REQ]) begin
                    m_win    = (m_rr + k) % NUM_REQ;
                    m_active = 1'b1;
                end
            end
            len   = int'(req_len[m_win*LEN_W +: LEN_W]);
            m_rem = (len == 0) ? (1 << LEN_W) : len;
        end
    endtask

    task automatic compare();
        check_eq("valid", 32'(out_valid), 32'(m_active));
        check_eq("gnt", 32'(gnt), m_active ? (32'd1 << m_win) : 32'd0);
        check_eq("busy", 32'(busy), 32'(m_active));
        check_eq("last", 32'(out_last), 32'(m_active && (m_rem == 1)));
        if (m_active) begin
            check_eq("data", 32'(out_data), 32'(seq_tab[m_pos]));
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*LEN_W-1:0] l, input logic rdy);
        req       = r;
        req_len   = l;
        out_ready = rdy;
        model_edge();
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req       = '0;
        req_len   = '0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare();
        check_eq("reset_last", 32'(out_last), 32'd0);

        // Single request of 3 beats, then a shared-position burst of 4 from requester 2.
        step(4'b0001, 16'h0003, 1'b1);
        check_eq("t1_first", 32'(out_data), 32'd1);
        for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000, 1'b1);
        step(4'b0100, 16'h0400, 1'b1);
        check_eq("t2_first", 32'(out_data), 32'd6);
        for (int i = 0; i < 5; i++) step(4'b0000, 16'h0000, 1'b1);

        // Round-robin with every requester active and length 1.
        do_reset();
        for (int i = 0; i < 10; i++) step(4'b1111, 16'h1111, 1'b1);

        // Backpressure: hold beat 1 for three cycles.
        step(4'b0001, 16'h0002, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0001, 16'h0002, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 16'h0000, 1'b1);

        // Length field zero means a 16-beat burst.
        step(4'b0010, 16'h0000, 1'b1);
        for (int i = 0; i < 17; i++) step(4'b0000, 16'hFFFF, 1'b1);

        // Reset on beat 2 of a 5-beat burst; next burst restarts at value 1.
        step(4'b0001, 16'h0005, 1'b1);
        step(4'b0000, 16'h0005, 1'b1);
        do_reset();
        step(4'b1000, 16'h1000, 1'b1);
        check_eq("t6_restart", 32'(out_data), 32'd1);
        step(4'b0000, 16'h0000, 1'b1);

        // Random traffic with changing requests, lengths and ready, plus occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(NUM_REQ'($urandom_range(0, 15) & $urandom_range(0, 15)),
                     (NUM_REQ*LEN_W)'($urandom & 32'h7373),
                     ($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
